fir_transpose_pipeline: RTL and testbench
=========================================

// Module: fir_transpose_pipeline
// PURPOSE
//  Pipelined transposed-form FIR filter: y[n] = sum_k tap_coeffs[k]*x[n-k], k=0..NUM_TAPS-1.
//  Signed streaming sample in, signed sample out, one sample per clock.
//  Taps come from a live coefficient port; no handshake.
//  Core arithmetic stage of the interpolation filter chain.
// PARAMETERS
//  DATA_WIDTH       5   signed width of in and out
//  TAP_COEFF_WIDTH  5   signed width of each coefficient
//  NUM_TAPS         50  number of taps (>=2)
//  OUT_SHIFT        TAP_COEFF_WIDTH-1  arithmetic right shift applied to the accumulator before output
// PORTS
//  clk         in   1                           single clock; all state updates on posedge
//  rst         in   1                           synchronous, active-high reset
//  in          in   DATA_WIDTH signed           input sample, accepted every cycle
//  out         out  DATA_WIDTH signed           filtered output sample
//  tap_coeffs  in   [TAP_COEFF_WIDTH-1:0] x [NUM_TAPS-1:0] signed
//              unpacked array; gate-level netlist uses flat vector, tap i at [W*(i+1)-1:W*i]
// BEHAVIOUR
//  - Widths:
//    - PW = DATA_WIDTH+TAP_COEFF_WIDTH for products.
//    - AW = PW+$clog2(NUM_TAPS) for the accumulator chain.
//    - All math is signed, full precision, with no internal overflow.
//  - Pipeline, all registers updated on posedge clk:
//    - s1: x_q <= in
//    - s2: prod[k] <= x_q * tap_coeffs[k], for every k
//    - s3: acc[k] <= prod[k] + acc[k+1], with acc[NUM_TAPS] == 0 (transposed chain)
//    - s4: out <= reduce(acc[0] >>> OUT_SHIFT)
//  - Latency:
//    - A sample presented before edge e contributes tap 0 to out after edge e+3 (4 cycles).
//    - Tap k appears k cycles later.
//  - Coefficients:
//    - Sampled every cycle at s2, quasi-static.
//    - A change affects products from the next edge on; no glitch protection.
//  - Reset (rst=1 at a posedge):
//    - x_q, all prod, all acc and out clear to 0 at that edge.
//    - out holds 0 while rst is high.
//    - Mid-stream reset discards all history.
//    - After release, out reflects only samples accepted after release, with the latency above.
//  - No valid/ready: every cycle is a sample, including cycles where in is X-free 0.
//  - Reduction of the shifted accumulator to DATA_WIDTH: see CONFIGURATION.
//  - Arithmetic shift floors toward -inf; e.g. 45>>>4 = 2, -45>>>4 = -3.
// CONFIGURATION
//  FIR_SATURATE_EN
//  - Defined:
//    - Shifted accumulator is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//    - Default widths give [-16, 15].
//  - Undefined: shifted accumulator is truncated to its low DATA_WIDTH bits (two's-complement wrap).
//  - Latency and reset are identical in both builds.
// TESTING (DATA_WIDTH=5, TAP_COEFF_WIDTH=5, NUM_TAPS=50, OUT_SHIFT=4)
//  - Reset:
//    - Stimulus: rst=1 for 2 cycles with in=-1 ramping.
//    - Required: out==0 throughout and for the first 3 edges after release.
//  - Impulse:
//    - Stimulus: taps 0..3 = 3, others 0; in=15 for one cycle, then 0.
//    - Required: out==2 for exactly 4 cycles starting 4 cycles later, then 0.
//  - Step:
//    - Stimulus: same taps; in held at 8.
//    - Required: out sequence 1,3,4,6, then 6 steady.
//  - Saturate:
//    - Stimulus: all taps=15; in held at 15 (acc=11250, shifted=703).
//    - Required: out settles at 15 with FIR_SATURATE_EN, at -1 without.
//  - Negative:
//    - Stimulus: all taps=15; in held at -16.
//    - Required: out settles at -16 with FIR_SATURATE_EN, at -14 without (-750 wrapped).
//  - Ramp and mid-stream reset:
//    - Stimulus: in ramps +1 per cycle from -1 (wraps at 15 to -16); taps 0..3=3; rst pulsed for 1 cycle mid-ramp.
//    - Required: out matches a golden model exactly every cycle, and restarts from 0 history after the pulse.

Source files
------------

// File: rtl/fir_transpose_pipeline.sv
// Pipelined transposed-form FIR filter, one signed sample in and one out per clock.
// Build option: define FIR_SATURATE_EN to clamp the output; otherwise it wraps.
module fir_transpose_pipeline #(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 50,
  parameter int OUT_SHIFT       = TAP_COEFF_WIDTH - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [DATA_WIDTH-1:0]      in,
  input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS-1:0],
  output logic signed [DATA_WIDTH-1:0]      out
);

  localparam int PW = DATA_WIDTH + TAP_COEFF_WIDTH;
  localparam int AW = PW + $clog2(NUM_TAPS);

  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [PW-1:0]         prod [NUM_TAPS-1:0];
  logic signed [AW-1:0]         acc  [NUM_TAPS-1:0];
  logic signed [DATA_WIDTH-1:0] out_d;

`ifdef FIR_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [AW-1:0] shifted;

  assign shifted = acc[0] >>> OUT_SHIFT;

  always_comb begin
    out_d = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      out_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      out_d = SAT_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  assign out_d = DATA_WIDTH'(acc[0] >>> OUT_SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      out <= '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      x_q <= in;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= PW'(x_q) * PW'(tap_coeffs[k]);
      end
      // Transposed chain: each stage adds its product to the partial sum one tap further out.
      for (int unsigned k = 0; k < NUM_TAPS - 1; k++) begin
        acc[k] <= AW'(prod[k]) + acc[k+1];
      end
      acc[NUM_TAPS-1] <= AW'(prod[NUM_TAPS-1]);
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_fir_transpose_pipeline.sv
// Randomized and directed bench for fir_transpose_pipeline against a convolution reference model.
// Honours FIR_SATURATE_EN the same way as the design.
module tb_fir_transpose_pipeline;

  localparam int DW = 5;
  localparam int CW = 5;
  localparam int NT = 50;
  localparam int SH = CW - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] y_out;
  logic signed [CW-1:0] taps [NT-1:0];

  int errors = 0;
  int checks = 0;
  int coef [NT];
  int hist [$];
  int got;

  always #5 clk = ~clk;

  fir_transpose_pipeline #(
    .DATA_WIDTH      (DW),
    .TAP_COEFF_WIDTH (CW),
    .NUM_TAPS        (NT),
    .OUT_SHIFT       (SH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (x_in),
    .out        (y_out),
    .tap_coeffs (taps)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int reduce(input int a);
    int s;
    s = a >>> SH;
`ifdef FIR_SATURATE_EN
    if (s > 15) s = 15;
    if (s < -16) s = -16;
`else
    s = s & 31;
    if (s >= 16) s = s - 32;
`endif
    return s;
  endfunction

  // y[n] = sum c[k]*x[n-k] over samples accepted since the last reset; out lags by 4 edges.
  function automatic int model_out();
    int     n;
    longint sum;
    n   = hist.size() - 4;
    sum = 0;
    if (n < 0) return 0;
    for (int k = 0; k < NT; k++) begin
      if (n - k >= 0) sum += longint'(coef[k]) * longint'(hist[n-k]);
    end
    return reduce(int'(sum));
  endfunction

  task automatic set_taps(input int mode, input int val);
    for (int k = 0; k < NT; k++) begin
      case (mode)
        0:       coef[k] = (k < 4) ? val : 0;
        1:       coef[k] = val;
        default: coef[k] = $urandom_range(31) - 16;
      endcase
      taps[k] = CW'(coef[k]);
    end
  endtask

  task automatic cycle(input bit r, input int x, input string tag, output int obs);
    @(negedge clk);
    rst  = r;
    x_in = DW'(x);
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else   hist.push_back(int'(x_in));
    obs = int'(y_out);
    check(tag, obs, r ? 0 : model_out());
  endtask

  task automatic do_reset(input int n);
    int o;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, -1 + i, "reset", o);
      check("reset_zero", o, 0);
    end
  endtask

  initial begin
    int o;
    int x;
    set_taps(0, 3);

    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1 + i, "post_reset", o);
      check("post_reset_zero", o, 0);
    end

    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, (i == 0) ? 15 : 0, "impulse", o);
      check("impulse_const", o, (i >= 3 && i <= 6) ? 2 : 0);
    end

    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      int step_exp [4] = '{1, 3, 4, 6};
      cycle(1'b0, 8, "step", o);
      check("step_const", o, (i < 3) ? 0 : (i < 7) ? step_exp[i-3] : 6);
    end

    set_taps(1, 15);
    do_reset(2);
    for (int i = 0; i < 60; i++) cycle(1'b0, 15, "sat_pos", o);
`ifdef FIR_SATURATE_EN
    check("sat_pos_final", o, 15);
`else
    check("sat_pos_final", o, -1);
`endif

    do_reset(2);
    for (int i = 0; i < 60; i++) cycle(1'b0, -16, "sat_neg", o);
`ifdef FIR_SATURATE_EN
    check("sat_neg_final", o, -16);
`else
    check("sat_neg_final", o, -14);
`endif

    set_taps(0, 3);
    do_reset(2);
    x = -1;
    for (int i = 0; i < 60; i++) begin
      bit r;
      r = (i == 25);
      cycle(r, x, "ramp", o);
      if (i >= 26 && i <= 28) check("ramp_restart_zero", o, 0);
      x = (x == 15) ? -16 : x + 1;
    end

    set_taps(2, 0);
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      bit r;
      r = ($urandom_range(39) == 0);
      cycle(r, $urandom_range(31) - 16, "random", o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
